// File: rtl/mem_excp_pkg.sv
// Shared CPU defines for the MEM-stage exception unit: exception codes,
// CP0 register indices and the MEM pipeline register layout.
package mem_excp_pkg;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ERET = 5'h11;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        in_delay;
    logic [3:0]  flags;      // {eret, ri, break, syscall}
    logic        ov;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] addr;
    logic        rf_we;
  } mem_reg_t;

  // Bytes are never misaligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_HALF: mis = addr_lo[0];
      SIZE_WORD: mis = |addr_lo;
      default:   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_excp_if.sv
// EX-to-MEM instruction descriptor bus; EX drives it, the MEM stage consumes it.
interface mem_excp_if;
  logic        ex_valid_i;
  logic [31:0] ex_pc_i;
  logic        ex_in_delay_i;
  logic [3:0]  ex_flags_i;
  logic        ex_ov_i;
  logic        ex_mem_rd_i;
  logic        ex_mem_wr_i;
  logic [1:0]  ex_mem_size_i;
  logic [31:0] ex_addr_i;
  logic        ex_rf_we_i;

  modport master (
    output ex_valid_i, ex_pc_i, ex_in_delay_i, ex_flags_i, ex_ov_i,
           ex_mem_rd_i, ex_mem_wr_i, ex_mem_size_i, ex_addr_i, ex_rf_we_i
  );

  modport slave (
    input ex_valid_i, ex_pc_i, ex_in_delay_i, ex_flags_i, ex_ov_i,
          ex_mem_rd_i, ex_mem_wr_i, ex_mem_size_i, ex_addr_i, ex_rf_we_i
  );
endinterface

// File: rtl/mem_pipe_reg.sv
// MEM pipeline register: reset beats flush, flush beats stall, otherwise load.
module mem_pipe_reg
  import mem_excp_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     stall,
  input  logic     flush,
  input  mem_reg_t d,
  output mem_reg_t q
);

  // NOTE: non-blocking (<=) for every register update so all flops sample
  // the pre-edge value; the reset is synchronous, so it only acts on an edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_excp.sv
// MEM-stage exception detection: registers the EX descriptor and reports the
// highest-priority exception of the held instruction to CP0 combinationally.
module mem_excp #(
  parameter logic [4:0] EXC_NONE = mem_excp_pkg::EXC_NONE,
  parameter logic [4:0] EXC_ERET = mem_excp_pkg::EXC_ERET
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  mem_excp_if.slave   ex,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [4:0]  exccode_o,
  output logic [31:0] pc_o,
  output logic        in_delay_o,
  output logic [31:0] badvaddr_o,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic        rf_we_o
);
  import mem_excp_pkg::mem_reg_t;
  import mem_excp_pkg::EXC_INT;
  import mem_excp_pkg::EXC_ADEL;
  import mem_excp_pkg::EXC_ADES;
  import mem_excp_pkg::EXC_SYS;
  import mem_excp_pkg::EXC_BP;
  import mem_excp_pkg::EXC_RI;
  import mem_excp_pkg::EXC_OV;
  import mem_excp_pkg::CP0_STATUS;
  import mem_excp_pkg::CP0_CAUSE;
  import mem_excp_pkg::is_misaligned;

  mem_reg_t    d, q;
  logic [31:0] eff_status, eff_cause;
  logic        int_pend, misalign, adel, ades, addr_exc, no_exc;

  assign d = '{valid:    ex.ex_valid_i,
               pc:       ex.ex_pc_i,
               in_delay: ex.ex_in_delay_i,
               flags:    ex.ex_flags_i,
               ov:       ex.ex_ov_i,
               mem_rd:   ex.ex_mem_rd_i,
               mem_wr:   ex.ex_mem_wr_i,
               mem_size: ex.ex_mem_size_i,
               addr:     ex.ex_addr_i,
               rf_we:    ex.ex_rf_we_i};

  mem_pipe_reg u_pipe_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall_i),
    .flush (flush_i),
    .d     (d),
    .q     (q)
  );

  // A CP0 write retiring in WB this cycle must be seen, or an interrupt
  // masked by that very write would still fire.
  assign eff_status = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_STATUS) ? wb_cp0_wdata_i : cp0_status_i;
  assign eff_cause  = (wb_cp0_we_i && wb_cp0_waddr_i == CP0_CAUSE)  ? wb_cp0_wdata_i : cp0_cause_i;
  assign int_pend   = eff_status[0] & ~eff_status[1] & (|(eff_cause[15:8] & eff_status[15:8]));

  assign misalign = is_misaligned(q.mem_size, q.addr[1:0]);
  assign adel     = q.valid & ~int_pend & misalign & q.mem_rd;
  assign ades     = q.valid & ~int_pend & misalign & q.mem_wr & ~q.mem_rd;
  assign addr_exc = adel | ades;

  // NOTE: exccode_o gets its default first so no path through the priority
  // chain leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    exccode_o = EXC_NONE;
    if (q.valid) begin
      if (int_pend)                      exccode_o = EXC_INT;
      else if (misalign && q.mem_rd)     exccode_o = EXC_ADEL;
      else if (misalign && q.mem_wr)     exccode_o = EXC_ADES;
      else if (q.flags[0])               exccode_o = EXC_SYS;
      else if (q.flags[1])               exccode_o = EXC_BP;
      else if (q.flags[2])               exccode_o = EXC_RI;
      else if (q.ov)                     exccode_o = EXC_OV;
      else if (q.flags[3])               exccode_o = EXC_ERET;
    end
  end

  assign no_exc     = q.valid & (exccode_o == EXC_NONE);
  assign pc_o       = q.pc;
  assign in_delay_o = q.in_delay;
  assign badvaddr_o = addr_exc ? q.addr : 32'h0;
  assign mem_rd_o   = q.mem_rd & no_exc;
  assign mem_wr_o   = q.mem_wr & no_exc;
  assign rf_we_o    = q.rf_we  & no_exc;

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{eff_status[31:16], eff_status[7:2], eff_cause[31:16], eff_cause[7:0]};

endmodule

// File: tb/tb_mem_excp.sv
// Directed bench for mem_excp: a behavioural model of the MEM-stage
// exception rules is compared with the DUT every cycle, plus literal pins.
module tb_mem_excp;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush;
  logic [31:0] status, cause;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  exccode;
  logic [31:0] pc, badvaddr;
  logic        in_delay, mem_rd, mem_wr, rf_we;

  int n_checks = 0;
  int n_errors = 0;

  mem_excp_if ex_bus ();

  mem_excp dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .flush_i        (flush),
    .ex             (ex_bus),
    .cp0_status_i   (status),
    .cp0_cause_i    (cause),
    .wb_cp0_we_i    (wb_we),
    .wb_cp0_waddr_i (wb_addr),
    .wb_cp0_wdata_i (wb_data),
    .exccode_o      (exccode),
    .pc_o           (pc),
    .in_delay_o     (in_delay),
    .badvaddr_o     (badvaddr),
    .mem_rd_o       (mem_rd),
    .mem_wr_o       (mem_wr),
    .rf_we_o        (rf_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the instruction currently sitting in MEM, as plain fields.
  typedef struct {
    bit          valid;
    int unsigned pc;
    bit          delay;
    bit          eret, ri, brk, sys, ov;
    bit          rd, wr;
    int unsigned size;
    int unsigned addr;
    bit          rfwe;
  } instr_t;

  instr_t m;
  bit     model_ok = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m = '{default: 0};
      model_ok = 1;
    end else if (flush) begin
      m.valid = 0;
    end else if (!stall) begin
      m.valid = ex_bus.ex_valid_i;
      m.pc    = ex_bus.ex_pc_i;
      m.delay = ex_bus.ex_in_delay_i;
      m.eret  = ex_bus.ex_flags_i[3];
      m.ri    = ex_bus.ex_flags_i[2];
      m.brk   = ex_bus.ex_flags_i[1];
      m.sys   = ex_bus.ex_flags_i[0];
      m.ov    = ex_bus.ex_ov_i;
      m.rd    = ex_bus.ex_mem_rd_i;
      m.wr    = ex_bus.ex_mem_wr_i;
      m.size  = ex_bus.ex_mem_size_i;
      m.addr  = ex_bus.ex_addr_i;
      m.rfwe  = ex_bus.ex_rf_we_i;
    end
  end

  function automatic int unsigned model_code();
    int unsigned st, ca;
    bit mis;
    if (!m.valid) return 'h10;
    st = (wb_we && wb_addr == 12) ? wb_data : status;
    ca = (wb_we && wb_addr == 13) ? wb_data : cause;
    if ((st % 2 == 1) && ((st / 2) % 2 == 0) && ((((st >> 8) & ca >> 8) & 'hFF) != 0)) return 'h00;
    mis = (m.size == 1 && m.addr % 2 != 0) || (m.size == 2 && m.addr % 4 != 0);
    if (mis && m.rd) return 'h04;
    if (mis && m.wr) return 'h05;
    if (m.sys)  return 'h08;
    if (m.brk)  return 'h09;
    if (m.ri)   return 'h0a;
    if (m.ov)   return 'h0c;
    if (m.eret) return 'h11;
    return 'h10;
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      int unsigned code;
      bit ok;
      code = model_code();
      ok   = m.valid && code == 'h10;
      check("cmp_exccode",  exccode,  code);
      check("cmp_badvaddr", badvaddr, (code == 'h04 || code == 'h05) ? m.addr : 0);
      check("cmp_mem_rd",   mem_rd,   m.rd && ok);
      check("cmp_mem_wr",   mem_wr,   m.wr && ok);
      check("cmp_rf_we",    rf_we,    m.rfwe && ok);
      if (m.valid) begin
        check("cmp_pc",       pc,       m.pc);
        check("cmp_in_delay", in_delay, m.delay);
      end
    end
  end

  task automatic set_ex(input bit v, input logic [31:0] p, input bit dly, input logic [3:0] fl,
                        input bit o, input bit rd, input bit wr, input logic [1:0] sz,
                        input logic [31:0] a, input bit we);
    ex_bus.ex_valid_i    = v;
    ex_bus.ex_pc_i       = p;
    ex_bus.ex_in_delay_i = dly;
    ex_bus.ex_flags_i    = fl;
    ex_bus.ex_ov_i       = o;
    ex_bus.ex_mem_rd_i   = rd;
    ex_bus.ex_mem_wr_i   = wr;
    ex_bus.ex_mem_size_i = sz;
    ex_bus.ex_addr_i     = a;
    ex_bus.ex_rf_we_i    = we;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    status = 0; cause = 0; wb_we = 0; wb_addr = 0; wb_data = 0;
    set_ex(1, 32'h0000_0abc, 1, 4'b0001, 0, 1, 0, 2, 32'h1000, 1);
    step();
    step();
    check("rst_exccode", exccode, 5'h10);
    check("rst_pc", pc, 0);
    check("rst_rf_we", rf_we, 0);

    rst_n = 1;
    set_ex(1, 32'h100, 0, 4'b0000, 0, 1, 0, 2, 32'h1000, 1);
    step();
    check("lw_ok_rd", mem_rd, 1);
    check("lw_ok_pc", pc, 32'h100);

    set_ex(1, 32'h104, 1, 4'b0000, 0, 1, 0, 2, 32'h1002, 1);
    step();
    check("adel_code", exccode, 5'h04);
    check("adel_badvaddr", badvaddr, 32'h0000_1002);
    check("adel_mem_rd", mem_rd, 0);

    set_ex(1, 32'h108, 0, 4'b0000, 0, 0, 1, 1, 32'h2001, 0);
    step();
    check("ades_code", exccode, 5'h05);
    set_ex(1, 32'h10c, 0, 4'b0000, 0, 1, 0, 0, 32'h3003, 1);
    step();
    check("lb_odd_code", exccode, 5'h10);
    set_ex(1, 32'h110, 0, 4'b0000, 0, 0, 1, 1, 32'h2002, 0);
    step();
    check("sh_ok_wr", mem_wr, 1);

    status = 32'h0000_0401; cause = 32'h0000_0400;
    set_ex(1, 32'h114, 0, 4'b0001, 0, 0, 0, 2, 32'h0, 1);
    step();
    check("int_code", exccode, 5'h00);
    check("int_rf_we", rf_we, 0);
    wb_we = 1; wb_addr = 12; wb_data = 32'h0000_0400;
    #1;
    check("wb_mask_code", exccode, 5'h08);
    wb_addr = 13; wb_data = 32'h0;
    #1;
    check("wb_cause_code", exccode, 5'h08);
    wb_we = 0;
    set_ex(0, 32'h118, 0, 4'b0000, 0, 0, 0, 2, 32'h0, 1);
    step();
    check("bubble_no_int", exccode, 5'h10);
    status = 0; cause = 0;

    set_ex(1, 32'h11c, 0, 4'b0010, 0, 0, 0, 2, 32'h0, 0);
    step();
    check("bp_code", exccode, 5'h09);
    set_ex(1, 32'h120, 0, 4'b0100, 1, 0, 0, 2, 32'h0, 0);
    step();
    check("ri_code", exccode, 5'h0a);
    set_ex(1, 32'h124, 0, 4'b0000, 1, 0, 0, 2, 32'h0, 1);
    step();
    check("ov_code", exccode, 5'h0c);
    set_ex(1, 32'h128, 0, 4'b0011, 0, 0, 0, 2, 32'h0, 0);
    step();
    check("sys_over_bp", exccode, 5'h08);

    set_ex(1, 32'h200, 1, 4'b1000, 0, 0, 0, 2, 32'h0, 0);
    step();
    stall = 1;
    set_ex(1, 32'h204, 0, 4'b0001, 0, 0, 0, 2, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("eret_stall", exccode, 5'h11);
    end
    flush = 1; stall = 0;
    step();
    check("eret_flushed", exccode, 5'h10);
    flush = 0;

    set_ex(1, 32'h300, 0, 4'b0000, 0, 1, 0, 2, 32'h4000, 1);
    step();
    stall = 1; flush = 1;
    step();
    check("stall_flush_rd", mem_rd, 0);
    flush = 0; stall = 0;
    step();
    check("reload_rd", mem_rd, 1);
    stall = 1;
    step();
    rst_n = 0;
    step();
    check("rst_stall_code", exccode, 5'h10);
    check("rst_stall_pc", pc, 0);
    check("rst_stall_rd", mem_rd, 0);
    rst_n = 1; stall = 0;
    set_ex(0, 32'h0, 0, 4'b0000, 0, 0, 0, 0, 32'h0, 0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
